// File: rtl/div_request_sequencer_pkg.sv
// Shared types and constants for the divide request sequencer.
// State encoding matches the engine controller's view of the handshake.
package div_request_sequencer_pkg;

  localparam int DIV_W       = 5;
  localparam int DIV_TIMEOUT = 64;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOADB = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CLR   = 3'd4,
    ST_RESP  = 3'd5
  } div_state_e;

endpackage

// File: rtl/div_timeout_counter.sv
// Watchdog for the WAIT phase: counts engine cycles and flags
// when the last permitted cycle is reached.
module div_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/div_request_sequencer.sv
// Request front-end for the repeated-subtraction divider: sequences
// operands onto the shared bus and returns results or errors.
module div_request_sequencer
  import div_request_sequencer_pkg::*;
#(
  parameter int W       = DIV_W,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_dividend,
  input  logic [W-1:0] req_divisor,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_quotient,
  output logic [W-1:0] rsp_remainder,
  output logic         rsp_err,
  output logic         div_start,
  output logic [W-1:0] div_data,
  input  logic         div_done,
  input  logic [W-1:0] div_quot,
  input  logic [W-1:0] div_rem,
  output logic         div_clr
);

  div_state_e state_q, state_d;

  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] data_q, data_d;
  logic         err_q, err_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         start_q, start_d;
  logic         clr_q, clr_d;
  logic         cnt_clr, cnt_en, expired;

  div_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dvd_d = req_dividend;
          dvs_d = req_divisor;
          if (req_divisor == '0) begin
            quo_d   = '1;
            rem_d   = req_dividend;
            err_d   = RSP_ERR;
            state_d = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_LOADB;
      ST_LOADB: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        // done has priority over a coincident timeout
        if (div_done) begin
          quo_d   = div_quot;
          rem_d   = div_rem;
          err_d   = RSP_OK;
          state_d = ST_CLR;
        end else if (expired) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = RSP_ERR;
          state_d = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    start_d = (state_d == ST_START);
    clr_d   = (state_d == ST_CLR);

    unique case (1'b1)
      (state_d == ST_START),
      (state_d == ST_LOADB): data_d = dvs_d;
      (state_d == ST_WAIT):  data_d = dvd_d;
      default:               data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      start_q <= start_d;
      clr_q   <= clr_d;
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = valid_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;
  assign div_start     = start_q;
  assign div_data      = data_q;
  assign div_clr       = clr_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer: behavioural engine plus an
// arithmetic reference for results, latency and engine activity.
module tb_div_request_sequencer;

  localparam int W   = 5;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_dividend = '0;
  logic [W-1:0] req_divisor = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_quotient;
  logic [W-1:0] rsp_remainder;
  logic         rsp_err;
  logic         div_start;
  logic [W-1:0] div_data;
  logic         div_done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic         div_clr;

  int total = 0;
  int bad   = 0;

  int           eng_n = 4;
  int           eng_cyc;
  logic [W-1:0] eng_a, eng_b;
  int           start_cnt = 0;
  int           clr_cnt = 0;

  div_request_sequencer #(.W(W), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .div_start     (div_start),
    .div_data      (div_data),
    .div_done      (div_done),
    .div_quot      (div_quot),
    .div_rem       (div_rem),
    .div_clr       (div_clr)
  );

  always #5 clk = ~clk;

  // Engine: latches B at start, A on first WAIT cycle, raises sticky
  // done eng_n WAIT cycles in, clears on div_clr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cyc  <= 0;
      eng_a    <= '0;
      eng_b    <= '0;
      div_done <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else if (div_clr) begin
      eng_cyc  <= 0;
      div_done <= 1'b0;
    end else if (div_start) begin
      eng_cyc <= 1;
      eng_b   <= div_data;
    end else if (eng_cyc > 0) begin
      eng_cyc <= eng_cyc + 1;
      if (eng_cyc == 2) eng_a <= div_data;
      if (eng_cyc == eng_n) begin
        div_done <= 1'b1;
        div_quot <= (eng_b == '0) ? '1 :
                    ((eng_cyc == 2 ? div_data : eng_a) / eng_b);
        div_rem  <= (eng_b == '0) ? '1 :
                    ((eng_cyc == 2 ? div_data : eng_a) % eng_b);
      end
    end
  end

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (div_clr)   clr_cnt   <= clr_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int n, output logic [W-1:0] q,
                       output logic [W-1:0] r, output logic e,
                       output int lat);
    if (b == 0) begin
      q = 5'h1f; r = a; e = 1'b1; lat = 1;
    end else if (n <= TMO) begin
      q = a / b; r = a % b; e = 1'b0; lat = 4 + n;
    end else begin
      q = 0; r = 0; e = 1'b1; lat = 4 + TMO;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int n, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic e,
                        output int lat, output int st, output int cl,
                        output logic [W-1:0] d1, output logic [W-1:0] d2,
                        output logic [W-1:0] d3);
    int s0, c0, k;
    s0 = start_cnt; c0 = clr_cnt; lat = -1;
    q = 0; r = 0; e = 0; d1 = 0; d2 = 0; d3 = 0;
    eng_n = n; req_dividend = a; req_divisor = b;
    req_valid = 1'b1; rsp_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 1) d1 = div_data;
      if (c == 2) d2 = div_data;
      if (c == 3) d3 = div_data;
      if (rsp_valid) begin
        lat = c; q = rsp_quotient; r = rsp_remainder; e = rsp_err;
        break;
      end
      step();
    end
    if (lat > 0) step();
    st = start_cnt - s0;
    cl = clr_cnt - c0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) step();
    total++;
    if ({req_ready, rsp_valid, rsp_err, div_start, div_clr,
         rsp_quotient, rsp_remainder, div_data} !== {5'b10000, 15'd0}) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {req_ready, rsp_valid, rsp_err, div_start, div_clr,
                rsp_quotient, rsp_remainder, div_data}, {5'b10000, 15'd0});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r, d1, d2, d3; logic e; int lat, st, cl;
    run_op(5'd13, 5'd4, 4, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd3, 5'd1, 1'b0}) begin
      bad++; $display("FAIL basic_result got=%0d/%0d/%0d exp=3/1/0", q, r, e);
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++;
    if (st !== 1 || cl !== 1) begin
      bad++; $display("FAIL basic_pulses got start=%0d clr=%0d exp=1,1", st, cl);
    end
    total++;
    if ({d1, d2, d3} !== {5'd4, 5'd4, 5'd13}) begin
      bad++; $display("FAIL basic_bus got=%0d,%0d,%0d exp=4,4,13", d1, d2, d3);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r, d1, d2, d3; logic e; int lat, st, cl;
    run_op(5'd7, 5'd0, 4, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd31, 5'd7, 1'b1}) begin
      bad++; $display("FAIL dbz_result got=%0d/%0d/%0d exp=31/7/1", q, r, e);
    end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    total++;
    if (st !== 0 || cl !== 0) begin
      bad++; $display("FAIL dbz_engine got start=%0d clr=%0d exp=0,0", st, cl);
    end
  endtask

  task automatic test_backpressure;
    int k;
    eng_n = 2; req_dividend = 5'd20; req_divisor = 5'd3;
    req_valid = 1'b1; rsp_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    step();
    req_dividend = 5'd1; req_divisor = 5'd1;
    k = 1;
    while (!rsp_valid && k < 100) begin step(); k++; end
    total++;
    if (k !== 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", k); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, req_ready, rsp_quotient, rsp_remainder, rsp_err}
          !== {2'b10, 5'd6, 5'd2, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%0d r=%0d e=%b exp v=1 rdy=0 q=6 r=2 e=0",
                 i, rsp_valid, req_ready, rsp_quotient, rsp_remainder, rsp_err);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid);
    end
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 100) begin step(); k++; end
    total++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {1'b1, 5'd1, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL bp_held_req got v=%b q=%0d r=%0d e=%b exp v=1 q=1 r=0 e=0",
               rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    step();
  endtask

  task automatic test_timeout;
    logic [W-1:0] q, r, d1, d2, d3; logic e; int lat, st, cl;
    run_op(5'd9, 5'd2, 1000, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd0, 5'd0, 1'b1} || lat !== 68) begin
      bad++; $display("FAIL timeout got=%0d/%0d/%0d lat=%0d exp=0/0/1 lat=68", q, r, e, lat);
    end
    total++;
    if (st !== 1 || cl !== 1) begin
      bad++; $display("FAIL timeout_pulses got start=%0d clr=%0d exp=1,1", st, cl);
    end
    run_op(5'd29, 5'd6, 64, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd4, 5'd5, 1'b0} || lat !== 68) begin
      bad++; $display("FAIL done_wins got=%0d/%0d/%0d lat=%0d exp=4/5/0 lat=68", q, r, e, lat);
    end
    run_op(5'd29, 5'd6, 65, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd0, 5'd0, 1'b1} || lat !== 68) begin
      bad++; $display("FAIL late_done got=%0d/%0d/%0d lat=%0d exp=0/0/1 lat=68", q, r, e, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r, d1, d2, d3; logic e; int lat, st, cl, k, c0;
    run_op(5'd31, 5'd5, 3, q, r, e, lat, st, cl, d1, d2, d3);
    eng_n = 1000; req_dividend = 5'd31; req_divisor = 5'd5; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    step();
    req_valid = 1'b0;
    repeat (5) step();
    total++;
    if (div_data !== 5'd31) begin
      bad++; $display("FAIL mid_wait_bus got=%0d exp=31", div_data);
    end
    c0 = clr_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, div_start, div_clr,
         rsp_quotient, rsp_remainder, div_data} !== {5'b10000, 15'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=%b",
               {req_ready, rsp_valid, rsp_err, div_start, div_clr,
                rsp_quotient, rsp_remainder, div_data}, {5'b10000, 15'd0});
    end
    #2 rst_n = 1'b1;
    step();
    run_op(5'd31, 5'd5, 4, q, r, e, lat, st, cl, d1, d2, d3);
    total++;
    if ({q, r, e} !== {5'd6, 5'd1, 1'b0} || lat !== 8) begin
      bad++; $display("FAIL post_reset got=%0d/%0d/%0d lat=%0d exp=6/1/0 lat=8", q, r, e, lat);
    end
    total++;
    if (clr_cnt - c0 !== 1) begin
      bad++; $display("FAIL reset_no_clr got=%0d exp=1", clr_cnt - c0);
    end
  endtask

  task automatic test_back_to_back;
    int k, c;
    eng_n = 3; req_dividend = 5'd10; req_divisor = 5'd3;
    req_valid = 1'b1; rsp_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    step();
    req_dividend = 5'd15; req_divisor = 5'd5;
    c = 1;
    while (!rsp_valid && c < 100) begin step(); c++; end
    total++;
    if ({c, rsp_quotient, rsp_remainder, rsp_err} !== {32'd7, 5'd3, 5'd1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_first got cyc=%0d q=%0d r=%0d e=%b exp cyc=7 q=3 r=1 e=0",
               c, rsp_quotient, rsp_remainder, rsp_err);
    end
    step();
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap got rdy=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    total++;
    if (div_start !== 1'b1) begin bad++; $display("FAIL b2b_restart got start=%b exp=1", div_start); end
    c = 1;
    while (!rsp_valid && c < 100) begin step(); c++; end
    total++;
    if ({c, rsp_quotient, rsp_remainder, rsp_err} !== {32'd7, 5'd3, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second got cyc=%0d q=%0d r=%0d e=%b exp cyc=7 q=3 r=0 e=0",
               c, rsp_quotient, rsp_remainder, rsp_err);
    end
    step();
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, d1, d2, d3, eq, er; logic e, ee;
    int n, lat, st, cl, elat;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, 31));
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 31));
      n = $urandom_range(2, 70);
      model(a, b, n, eq, er, ee, elat);
      run_op(a, b, n, q, r, e, lat, st, cl, d1, d2, d3);
      total++;
      if ({q, r, e} !== {eq, er, ee} || lat !== elat) begin
        bad++;
        $display("FAIL rand%0d %0d/%0d n=%0d got=%0d/%0d/%0d lat=%0d exp=%0d/%0d/%0d lat=%0d",
                 i, a, b, n, q, r, e, lat, eq, er, ee, elat);
      end
      total++;
      if (st !== int'(b != 0) || cl !== int'(b != 0)) begin
        bad++;
        $display("FAIL rand%0d_pulses got start=%0d clr=%0d exp=%0d", i, st, cl, int'(b != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
